// File: rtl/encode_decode_pkg.sv
// Shared Hamming(7,4) serial-link definitions: frame geometry, receiver states and syndrome math.
package encode_decode_pkg;

   localparam int FRAME_LEN = 8;
   localparam int DATA_W    = 4;
   localparam int PAR_W     = 3;

   typedef enum logic [1:0] {
      HUNT,
      RECV,
      EXPECT
   } state_t;

   // s0 covers d0,d1,d2; s1 covers d0,d1,d3; s2 covers d0,d2,d3
   function automatic logic [PAR_W-1:0] hamming74_syndrome(
      input logic [DATA_W-1:0] d,
      input logic [PAR_W-1:0]  p
   );
      hamming74_syndrome = {p[2] ^ d[0] ^ d[2] ^ d[3],
                            p[1] ^ d[0] ^ d[1] ^ d[3],
                            p[0] ^ d[0] ^ d[1] ^ d[2]};
   endfunction

endpackage

// File: rtl/hamming74_correct.sv
// Combinational Hamming(7,4) single-error corrector: flips the data bit the syndrome points at.
module hamming74_correct
   import encode_decode_pkg::*;
(
   input  logic [DATA_W-1:0] d,
   input  logic [PAR_W-1:0]  p,
   output logic [DATA_W-1:0] d_fix,
   output logic              err
);

   logic [PAR_W-1:0] syn;

   always_comb begin
      syn   = hamming74_syndrome(d, p);
      d_fix = d;
      // single-weight syndromes point at a parity bit, so data passes through
      case (syn)
         3'b111:  d_fix[0] = ~d[0];
         3'b011:  d_fix[1] = ~d[1];
         3'b101:  d_fix[2] = ~d[2];
         3'b110:  d_fix[3] = ~d[3];
         default: d_fix    = d;
      endcase
      err = |syn;
   end

endmodule

// File: rtl/decode.sv
// Serial Hamming(7,4) receiver: start-bit alignment, LSB-first deserialise, single-error correct.
//
//  state  | meaning
//  HUNT   | unaligned, waiting for a start-level bit
//  RECV   | capturing d0..d3,p0..p2 into the shift register
//  EXPECT | frame just decoded, next bit must be a start bit
module decode
   import encode_decode_pkg::*;
#(
   parameter logic START_LEVEL = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in,
   output logic [DATA_W-1:0] out,
   output logic              valid,
   output logic              corrected,
   output logic              sync_err,
   output logic              locked
);

   localparam logic [2:0] IDX_LAST = 3'(FRAME_LEN - 2);

   state_t            state_q, state_d;
   logic [2:0]        idx_q, idx_d;
   logic [6:0]        sr_q, sr_d;
   logic [6:0]        frame;
   logic [DATA_W-1:0] d_fix;
   logic              err;
   logic [DATA_W-1:0] out_d;
   logic              valid_d, corrected_d, sync_err_d, locked_d;

   // bits enter at the top, so after seven shifts sr[0] holds d0
   assign frame = {in, sr_q[6:1]};

   hamming74_correct u_correct (
      .d     (frame[3:0]),
      .p     (frame[6:4]),
      .d_fix (d_fix),
      .err   (err)
   );

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      sr_d        = sr_q;
      out_d       = out;
      corrected_d = corrected;
      locked_d    = locked;
      valid_d     = 1'b0;
      sync_err_d  = 1'b0;
      case (state_q)
         HUNT: begin
            locked_d = 1'b0;
            if (in == START_LEVEL) begin
               state_d = RECV;
               idx_d   = 3'd0;
            end
         end
         RECV: begin
            sr_d  = frame;
            idx_d = idx_q + 3'd1;
            if (idx_q == IDX_LAST) begin
               out_d       = d_fix;
               corrected_d = err;
               valid_d     = 1'b1;
               locked_d    = 1'b1;
               state_d     = EXPECT;
            end
         end
         EXPECT: begin
            if (in == START_LEVEL) begin
               state_d = RECV;
               idx_d   = 3'd0;
            end else begin
               sync_err_d = 1'b1;
               locked_d   = 1'b0;
               state_d    = HUNT;
            end
         end
         default: state_d = HUNT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= HUNT;
         idx_q     <= 3'd0;
         sr_q      <= 7'd0;
         out       <= '0;
         valid     <= 1'b0;
         corrected <= 1'b0;
         sync_err  <= 1'b0;
         locked    <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         sr_q      <= sr_d;
         out       <= out_d;
         valid     <= valid_d;
         corrected <= corrected_d;
         sync_err  <= sync_err_d;
         locked    <= locked_d;
      end
   end

endmodule
